// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the accumulator ALU sequencer.
package alu_seq_pkg;
    localparam int INSTR_W = 12;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXECUTE} state_t;

    localparam logic [3:0] OP_LDA  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decoder for the sequencer control path.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_lda,
    output logic       is_out,
    output logic       is_halt
);
    assign is_alu  = opcode < OP_LDA;
    assign is_lda  = opcode == OP_LDA;
    assign is_out  = opcode == OP_OUT;
    assign is_halt = opcode == OP_HALT;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute sequencer driving an external 8-bit accumulator ALU.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [DATA_W-1:0]  alu_acc,
    output logic [DATA_W-1:0]  alu_data,
    output logic [3:0]         alu_opcode,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  acc_out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);
    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   dreg;
    logic [3:0]          opcode_r;
    logic                is_alu, is_lda, is_out, is_halt;

    alu_seq_decode u_decode (
        .opcode  (opcode_r),
        .is_alu  (is_alu),
        .is_lda  (is_lda),
        .is_out  (is_out),
        .is_halt (is_halt)
    );

    // pc only changes on the start and EXECUTE edges, so it already holds steady through DECODE/EXECUTE
    assign prog_addr  = pc;
    assign alu_acc    = acc;
    assign alu_data   = dreg;
    assign alu_opcode = opcode_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            acc       <= '0;
            dreg      <= '0;
            opcode_r  <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    opcode_r <= prog_data[INSTR_W-1:DATA_W];
                    dreg     <= prog_data[DATA_W-1:0];
                    state    <= EXECUTE;
                end
                EXECUTE: begin
                    pc    <= pc + PC_W'(1);
                    state <= is_halt ? IDLE : FETCH;
                    acc   <= is_alu ? alu_result : is_lda ? dreg : acc;
                    if (is_out) begin
                        acc_out   <= acc;
                        out_valid <= 1'b1;
                    end
                    if (is_halt) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction sequencer for the 8-bit accumulator ALU. It fetches 12-bit instructions from a synchronous program ROM, loads the operand into the data register, and drives the ALU's accumulator, data and opcode inputs. On each ALU instruction it writes the ALU result back into the accumulator. It sits between the program memory and the ALU in the DSP core and provides a start/busy/done handshake to the host.

## Interface
Parameters:
- PC_W, 6: program counter width; the ROM depth is 2^PC_W words.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to run a program from address 0; honoured only in IDLE.
- prog_addr  out  PC_W  ROM address; the ROM returns data one cycle later.
- prog_data  in  12  instruction word: [11:8] opcode, [7:0] operand.
- alu_acc  out  8  accumulator register, to the ALU acc_in.
- alu_data  out  8  data register, to the ALU data_register.
- alu_opcode  out  4  opcode register, to the ALU opcode.
- alu_result  in  8  combinational ALU result.
- acc_out  out  8  accumulator value captured by the OUT instruction.
- out_valid  out  1  one-cycle strobe; acc_out was updated this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when HALT executes.

## Operation
Opcode map:
- 0x0–0xB: ALU operation. The opcode is passed to the ALU unchanged, and acc <= alu_result.
- 0xC: LDA. acc <= operand.
- 0xD: OUT. acc_out <= acc and out_valid is pulsed.
- 0xE: NOP.
- 0xF: HALT. done is pulsed and the FSM returns to IDLE.

State machine:
- IDLE → FETCH on start. This transition sets pc <= 0 and acc <= 0.
- FETCH: drive prog_addr = pc. Next state is DECODE.
- DECODE: latch prog_data into opcode_r and dreg (operand). Next state is EXECUTE.
- EXECUTE: perform the operation above and set pc <= pc+1. Next state is FETCH, or IDLE for HALT.

Boundary conditions:
- pc wraps from 2^PC_W−1 to 0 with no fault.
- A program with no HALT runs forever.
- start while busy is ignored.
- start in the same cycle that HALT executes is ignored; the host must re-assert start once busy is low.
- Reset mid-program aborts immediately to IDLE.
- alu_result is sampled only in EXECUTE for opcodes 0x0–0xB. Any carry out of the ALU is ignored.

Reset values:
- state = IDLE; pc, acc, dreg and opcode_r are 0.
- prog_addr = 0, alu_acc = 0, alu_data = 0, alu_opcode = 0, acc_out = 0.
- out_valid = 0, busy = 0, done = 0.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE); there is no pipelining.
- Start accepted at edge T0:
  - FETCH of instruction 0 in cycle T0+1.
  - EXECUTE of instruction 0 in cycle T0+3.
  - acc is updated at edge T0+3.
- alu_acc, alu_data and alu_opcode are registered. They are stable for the whole EXECUTE cycle, so the ALU has a full cycle of combinational settling time.
- out_valid and done are registered. Each is high for exactly the one cycle after the EXECUTE edge of OUT or HALT.
- busy falls in the same cycle that done rises.
- prog_addr is a registered copy of pc. It holds its value in DECODE and EXECUTE.

## Structure
- Package alu_seq_pkg:
  - state enum {IDLE, FETCH, DECODE, EXECUTE}.
  - opcode constants OP_LDA = 4'hC, OP_OUT = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF.
  - INSTR_W = 12 and DATA_W = 8.
- One sub-module, alu_seq_decode: a combinational decoder from the 4-bit opcode to the controls is_alu, is_lda, is_out, is_halt.
- The ALU itself is instantiated outside this block.

## Test plan
The bench ALU model treats opcode 0x0 as an 8-bit add and 0x1 as an 8-bit subtract.
- Program {C05, 003, D00, F00}, start → out_valid once with acc_out = 0x08; done 12 cycles after the start edge; busy low afterwards.
- Program {CFF, 002, D00, F00} → acc_out = 0x01 (the 8-bit add wraps).
- Program {C10, 103, E00, D00, F00} → acc_out = 0x0D; the NOP leaves acc unchanged.
- start pulsed during EXECUTE of instruction 1 → ignored; pc sequence and done timing are identical to an uninterrupted run.
- rst_n asserted during DECODE of the second instruction → all outputs at reset values asynchronously; a fresh start reruns from pc = 0 with acc = 0.
- PC_W = 2, program {E00, E00, E00, E00} (no HALT) → prog_addr cycles 0,1,2,3,0; busy stays high; done never asserts.
